bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
- Sequential packed-BCD to binary converter using reverse double dabble (shift right, subtract-3 correction).
- It is the inverse of the display path's binary-to-BCD stage.
- Sits between a BCD source (keypad/switch digit entry) and the multiplier operand inputs. It also serves as a round-trip checker for the display converter.
- Start/done handshake: en_in starts a conversion; bin_en flags a valid result.

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd_in.
- BIN_W, 14, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1. 9999 fits in 14 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en_in  input  1  start request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 in [3:0], most significant digit in the top nibble.
- bin  output  BIN_W  binary result; held until the next completed conversion.
- bin_en  output  1  one-cycle pulse: bin/err updated this cycle.
- busy  output  1  high from the capture edge until the bin_en cycle, inclusive.
- err  output  1  latched with bin: 1 means a captured digit was > 9.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - bin=0, bin_en=0, busy=0, err=0.
  - Shift register and iteration counter cleared.
  - Any conversion in flight is abandoned; no bin_en.
- Internal shift register sr has width 4*DIGITS+BIN_W: BCD section in the upper bits, binary section in the lower bits.
- Iteration counter cnt is sized ceil(log2(BIN_W+1)).
- States:
  - IDLE:
    - If en_in=1 at edge E0: capture bcd_in into the BCD section, zero the binary section, cnt=0, busy=1.
    - If any captured digit > 9: next state DONE with err_next=1.
    - Otherwise: next state SHIFT.
  - SHIFT, one step per edge:
    - sr shifted right by 1 (logical).
    - Then each BCD nibble of the shifted value with value >= 8 has 3 subtracted, in the same cycle (combinational).
    - cnt increments.
    - After BIN_W steps (edges E1..E_BIN_W), next state DONE.
  - DONE, one cycle:
    - At the entry edge, bin <= binary section (or 0 if err) and err <= err_next.
    - bin_en=1 and busy=1 during this cycle.
    - Next edge: IDLE, with bin_en=0 and busy=0.
- Latency:
  - Valid input: bin_en high in the cycle after edge E_{BIN_W+1} (15 edges after capture with defaults).
  - Invalid input: bin_en high after edge E1.
- Throughput: a new en_in is accepted on the edge that leaves DONE at the earliest. en_in held high gives back-to-back conversions separated only by the DONE cycle.
- en_in while busy is ignored, with no queuing. bcd_in changes after capture do not affect the result.
- bin, err: registered and stable between bin_en pulses. bin_en is never high two cycles in a row.
- Residual BCD section after BIN_W steps is zero for valid input. This is a verification assertion, not an output.

Decomposition:
- Shared package holds:
  - constant BCD_ADJ_THRESH=8 and BCD_ADJ_SUB=3.
  - the state encoding IDLE/SHIFT/DONE as named constants (2-bit).
  - a function bin_width(DIGITS) for the default check.
- One natural sub-module: bcd_adj_digit.
  - Combinational 4-bit in/out.
  - Output = in-3 if in>=8, else in.
  - Instantiated DIGITS times via generate.

Test Plan:
- Reset, then bcd_in=16'h0042, en_in pulse -> bin_en exactly 15 edges after capture; bin=14'd42, err=0; busy high for 16 cycles.
- bcd_in=16'h9999 -> bin=14'd9999 (0x270F), err=0. Then 16'h0000 -> bin=0, err=0.
- bcd_in=16'h12A4 -> bin_en after edge E1; err=1, bin=0. Next conversion 16'h0007 -> bin=7, err=0.
- Capture 16'h1234; pulse en_in with bcd_in=16'h5678 at cycle 5 of SHIFT -> single bin_en, bin=1234; no second result.
- Capture 16'h0500; assert rst=0 mid-SHIFT (cycle 7) -> outputs 0 immediately (asynchronously). After release: no bin_en until a new en_in. 16'h0500 then gives 500.
- Sweep 0..9999 with en_in held high -> bin matches the decimal value and bin_en spacing is 16 cycles. Also feed bin through the display's binary-to-BCD converter and require the original bcd_in back.

Source files
------------

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants, state encoding and width helper
// for the packed-BCD to binary converter.
package bcd_to_bin_seq_pkg;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold 10^digits - 1.
  function automatic int bin_width(input int digits);
    longint unsigned v;
    int w;
    v = 1;
    w = 0;
    for (int i = 0; i < digits; i++)
      v = v * 10;
    v = v - 1;
    while (v != 0) begin
      v = v >> 1;
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_adj.sv
// Per-digit correction step of reverse double dabble:
// a nibble that reached 8 or more after the shift loses 3.
module bcd_adj_digit
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= BCD_ADJ_THRESH) ? (d - BCD_ADJ_SUB) : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter
// (reverse double dabble, one bit per clock).
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_in,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin,
  output logic                  bin_en,
  output logic                  busy,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W);

  if (BIN_W < bin_width(DIGITS)) begin : g_width_chk
    $error("BIN_W too small for DIGITS");
  end

  state_t          state;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_sh;
  logic [SR_W-1:0] sr_next;
  logic [CW-1:0]   cnt;
  logic            err_pend;
  logic            bad_digit;
  logic            take;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_in[4*i +: 4] > 4'd9)
        bad_digit = 1'b1;
  end

  assign take  = en_in && (state == IDLE || state == DONE);
  assign sr_sh = sr >> 1;
  assign sr_next[BIN_W-1:0] = sr_sh[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj_digit u_adj (
      .d (sr_sh[BIN_W + 4*g +: 4]),
      .q (sr_next[BIN_W + 4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      bin      <= '0;
      bin_en   <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      bin_en <= 1'b0;
      if (take) begin
        sr       <= {bcd_in, {BIN_W{1'b0}}};
        busy     <= 1'b1;
        state    <= SHIFT;
        err_pend <= bad_digit;
        // A bad digit skips the shifts: the exit test fires next edge.
        cnt      <= bad_digit ? CNT_LAST : '0;
      end else begin
        unique case (state)
          SHIFT: begin
            if (cnt == CNT_LAST) begin
              state  <= DONE;
              bin    <= err_pend ? '0 : sr[BIN_W-1:0];
              err    <= err_pend;
              bin_en <= 1'b1;
            end else begin
              sr  <= sr_next;
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && state == SHIFT && cnt == CNT_LAST && !err_pend)
      assert (sr[SR_W-1:BIN_W] == '0);
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: latency, error path,
// busy handling, async reset and a back-to-back round-trip sweep.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_in = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [13:0] bin;
  logic        bin_en;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
  } exp_t;

  exp_t sb[$];

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk    (clk),
    .rst    (rst),
    .en_in  (en_in),
    .bcd_in (bcd_in),
    .bin    (bin),
    .bin_en (bin_en),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Display-path model: classic double dabble.
  function automatic logic [15:0] bin2bcd(input logic [13:0] b);
    logic [15:0] d;
    d = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int k = 0; k < 4; k++)
        if (d[k*4 +: 4] >= 4'd5)
          d[k*4 +: 4] = d[k*4 +: 4] + 4'd3;
      d = {d[14:0], b[i]};
    end
    return d;
  endfunction

  task automatic start(input logic [15:0] v,
                       input logic [13:0] eb,
                       input logic ee);
    exp_t e;
    e.bcd = v;
    e.bin = eb;
    e.err = ee;
    sb.push_back(e);
    bcd_in = v;
    en_in  = 1'b1;
    tick();
    en_in  = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit busy_ok,
                           output bit to);
    n = 0;
    busy_ok = 1'b1;
    do begin
      tick();
      n++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (bin_en !== 1'b1 && n < 40);
    to = (bin_en !== 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({bin, err, bin_en, busy} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want 0",
               {bin, err, bin_en, busy});
    end
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({bin, err, bin_en, busy} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want 0",
               {bin, err, bin_en, busy});
    end
  endtask

  task automatic test_basic();
    int n;
    bit bo, to;
    exp_t e;
    start(16'h0042, 14'd42, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy_e0: got %b want 1", busy);
    end
    wait_done(n, bo, to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL basic_timeout: got none want bin_en");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (n != 15) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d want 15", n);
    end
    n_cmp++;
    if (!bo) begin
      n_bad++;
      $display("FAIL basic_busy: got low want high");
    end
    n_cmp++;
    if (bin !== e.bin || err !== e.err) begin
      n_bad++;
      $display("FAIL basic_result: got %0d/%b want %0d/%b",
               bin, err, e.bin, e.err);
    end
    tick();
    n_cmp++;
    if (bin_en !== 1'b0 || busy !== 1'b0 || bin !== 14'd42) begin
      n_bad++;
      $display("FAIL basic_after: got en=%b busy=%b bin=%0d want 0 0 42",
               bin_en, busy, bin);
    end
  endtask

  task automatic test_extremes();
    int n;
    bit bo, to;
    exp_t e;
    logic [15:0] vals [2];
    logic [13:0] exps [2];
    vals[0] = 16'h9999;
    exps[0] = 14'd9999;
    vals[1] = 16'h0000;
    exps[1] = 14'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      start(vals[i], exps[i], 1'b0);
      wait_done(n, bo, to);
      n_cmp++;
      if (to) begin
        n_bad++;
        $display("FAIL extreme_timeout: got none want bin_en");
        return;
      end
      e = sb.pop_front();
      n_cmp++;
      if (bin !== e.bin || err !== e.err || n != 15) begin
        n_bad++;
        $display("FAIL extreme_%h: got %0d/%b n=%0d want %0d/%b n=15",
                 e.bcd, bin, err, n, e.bin, e.err);
      end
    end
  endtask

  task automatic test_invalid();
    int n;
    bit bo, to;
    exp_t e;
    tick();
    start(16'h12A4, 14'd0, 1'b1);
    wait_done(n, bo, to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL invalid_timeout: got none want bin_en");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (n != 1) begin
      n_bad++;
      $display("FAIL invalid_latency: got %0d want 1", n);
    end
    n_cmp++;
    if (bin !== e.bin || err !== e.err) begin
      n_bad++;
      $display("FAIL invalid_result: got %0d/%b want %0d/%b",
               bin, err, e.bin, e.err);
    end
    tick();
    start(16'h0007, 14'd7, 1'b0);
    wait_done(n, bo, to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL recover_timeout: got none want bin_en");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (bin !== e.bin || err !== e.err || n != 15) begin
      n_bad++;
      $display("FAIL recover_result: got %0d/%b n=%0d want %0d/%b n=15",
               bin, err, n, e.bin, e.err);
    end
  endtask

  task automatic test_ignore_busy();
    int n, extra;
    bit bo, to;
    exp_t e;
    tick();
    start(16'h1234, 14'd1234, 1'b0);
    repeat (4) tick();
    bcd_in = 16'h5678;
    en_in  = 1'b1;
    tick();
    en_in  = 1'b0;
    wait_done(n, bo, to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL busy_timeout: got none want bin_en");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (bin !== e.bin || err !== e.err || n != 10) begin
      n_bad++;
      $display("FAIL busy_result: got %0d/%b n=%0d want %0d/%b n=10",
               bin, err, n, e.bin, e.err);
    end
    extra = 0;
    repeat (40) begin
      tick();
      if (bin_en === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL busy_extra: got %0d pulses want 0", extra);
    end
  endtask

  task automatic test_async_reset();
    int n, extra;
    bit bo, to;
    exp_t e;
    tick();
    bcd_in = 16'h0500;
    en_in  = 1'b1;
    tick();
    en_in  = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bin, err, bin_en, busy} !== 17'd0) begin
      n_bad++;
      $display("FAIL areset_now: got %h want 0",
               {bin, err, bin_en, busy});
    end
    repeat (2) tick();
    rst = 1'b1;
    extra = 0;
    repeat (30) begin
      tick();
      if (bin_en === 1'b1 || busy === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL areset_quiet: got %0d active cycles want 0", extra);
    end
    start(16'h0500, 14'd500, 1'b0);
    wait_done(n, bo, to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL areset_timeout: got none want bin_en");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (bin !== e.bin || err !== e.err || n != 15) begin
      n_bad++;
      $display("FAIL areset_result: got %0d/%b n=%0d want %0d/%b n=15",
               bin, err, n, e.bin, e.err);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int n, idx;
    bit bo, to;
    exp_t e;
    for (int v = 0; v < 10000; v += 37)
      q.push_back(v);
    q.push_back(9999);
    tick();
    e.bcd = bcd_of(q[0]);
    e.bin = 14'(q[0]);
    e.err = 1'b0;
    sb.push_back(e);
    bcd_in = e.bcd;
    en_in  = 1'b1;
    tick();
    idx = 1;
    for (int i = 0; i < q.size(); i++) begin
      wait_done(n, bo, to);
      n_cmp++;
      if (to) begin
        n_bad++;
        $display("FAIL sweep_timeout: item %0d got none", i);
        en_in = 1'b0;
        break;
      end
      if (idx < q.size()) begin
        e.bcd = bcd_of(q[idx]);
        e.bin = 14'(q[idx]);
        e.err = 1'b0;
        sb.push_back(e);
        bcd_in = e.bcd;
        idx++;
      end else begin
        en_in = 1'b0;
      end
      e = sb.pop_front();
      n_cmp++;
      if (bin !== e.bin || err !== e.err) begin
        n_bad++;
        $display("FAIL sweep_bin: got %0d/%b want %0d/0",
                 bin, err, e.bin);
      end
      n_cmp++;
      if (bin2bcd(bin) !== e.bcd) begin
        n_bad++;
        $display("FAIL sweep_roundtrip: got %h want %h",
                 bin2bcd(bin), e.bcd);
      end
      n_cmp++;
      if (n != ((i == 0) ? 15 : 16)) begin
        n_bad++;
        $display("FAIL sweep_spacing: got %0d want %0d",
                 n, (i == 0) ? 15 : 16);
      end
    end
    en_in = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sweep_leftover: got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_invalid();
    test_ignore_busy();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
